// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO slave: synchronised level data, irq mask, W1C edge capture.
// Ports: clk, reset_n, s1 bus (address/chipselect/write_n/writedata/readdata), in_port, irq.
module pio_input_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] data_in;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_in = in_port;
    end else begin : g_sync
      logic [W-1:0] sync_q [SYNC_STAGES];
      logic [W-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++)
          sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_d[i];
        end
      end

      assign data_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [W-1:0] data_d_q, data_d_d;
  logic [W-1:0] irqmask_q, irqmask_d;
  logic [W-1:0] edgecap_q, edgecap_d;
  logic [31:0]  readdata_q, readdata_d;

  logic         wr;
  logic [W-1:0] rise, fall, evt, clr;
  logic         unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    wr       = chipselect & ~write_n;
    data_d_d = data_in;
    rise     = data_in & ~data_d_q;
    fall     = ~data_in & data_d_q;
    if (EDGE_TYPE == 0)      evt = rise;
    else if (EDGE_TYPE == 1) evt = fall;
    else                     evt = rise | fall;

    irqmask_d = irqmask_q;
    if (wr && address == 2'd2)
      irqmask_d = writedata[W-1:0];

    clr = '0;
    if (wr && address == 2'd3)
      clr = writedata[W-1:0];
    // new event wins over a same-cycle clear
    edgecap_d = (edgecap_q & ~clr) | evt;

    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[W-1:0] = data_in;
      2'd1: readdata_d        = '0;
      2'd2: readdata_d[W-1:0] = irqmask_q;
      2'd3: readdata_d[W-1:0] = edgecap_q;
      default: readdata_d     = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d_q   <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      data_d_q   <= data_d_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  generate
    if (IRQ_MODE == 0) begin : g_lvl
      assign irq = |(data_in & irqmask_q);
    end else begin : g_edge
      assign irq = |(edgecap_q & irqmask_q);
    end
  endgenerate

endmodule

// File: tb/tb_pio_input_irq.sv
// Bench for pio_input_irq: three instances (edge/8b, level/8b, any-edge/32b)
// on a shared bus; expectations queued in a scoreboard and drained per sample.
module tb_pio_input_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in8, in_lvl;
  logic [31:0] in32;
  logic [31:0] rd8, rd_lvl, rd32;
  logic        irq8, irq_lvl, irq32;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          src;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pio_input_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2),
                  .EDGE_TYPE(0), .IRQ_MODE(1)) u_e8 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in8),
    .readdata(rd8), .irq(irq8));

  pio_input_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2),
                  .EDGE_TYPE(0), .IRQ_MODE(0)) u_l8 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_lvl),
    .readdata(rd_lvl), .irq(irq_lvl));

  pio_input_irq #(.DATA_WIDTH(32), .SYNC_STAGES(2),
                  .EDGE_TYPE(2), .IRQ_MODE(1)) u_a32 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in32),
    .readdata(rd32), .irq(irq32));

  function automatic logic [31:0] obs(int src);
    case (src)
      0:       return rd8;
      1:       return {31'b0, irq8};
      2:       return rd_lvl;
      3:       return {31'b0, irq_lvl};
      4:       return rd32;
      default: return {31'b0, irq32};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic ex(int src, string tag, logic [31:0] val);
    exp_t e;
    e.src = src;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.src), e.val);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_reg(logic [1:0] a, logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic all_zero(string tag);
    ex(0, {tag, "_rd8"}, 32'h0);
    ex(1, {tag, "_irq8"}, 32'h0);
    ex(2, {tag, "_rdl"}, 32'h0);
    ex(3, {tag, "_irql"}, 32'h0);
    ex(4, {tag, "_rd32"}, 32'h0);
    ex(5, {tag, "_irq32"}, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in8        = '0;
    in_lvl     = '0;
    in32       = '0;
    steps(3);
    reset_n = 1'b1;

    // reset/idle: every address reads zero
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      step();
      all_zero($sformatf("rst_a%0d", a));
      drain();
    end

    // level data through 2-stage synchroniser
    address = 2'd0;
    in8 = 8'hA5;
    steps(2);
    ex(0, "data_early", 32'h0);
    drain();
    step();
    ex(0, "data_a5", 32'h0000_00A5);
    drain();
    address = 2'd1;
    step();
    ex(0, "resv_rd", 32'h0);
    drain();
    address = 2'd3;
    step();
    ex(0, "ecap_a5", 32'h0000_00A5);
    drain();
    wr_reg(2'd3, 32'hFF);
    step();
    ex(0, "ecap_clr", 32'h0);
    drain();

    // single-cycle pulse on bit 0, edge irq
    in8 = 8'h00;
    steps(3);
    wr_reg(2'd2, 32'h01);
    in8 = 8'h01;
    step();
    in8 = 8'h00;
    step();
    ex(1, "pulse_irq_early", 32'h0);
    drain();
    step();
    ex(1, "pulse_irq", 32'h1);
    drain();
    address = 2'd3;
    step();
    ex(0, "pulse_ecap", 32'h01);
    drain();
    wr_reg(2'd3, 32'h01);
    ex(1, "pulse_irq_clr", 32'h0);
    drain();
    step();
    ex(0, "pulse_ecap_clr", 32'h0);
    drain();

    // rising edge coincides with W1C of the same bit
    wr_reg(2'd2, 32'h04);
    in8 = 8'h04;
    step();
    in8 = 8'h00;
    step();
    in8 = 8'h04;
    step();
    ex(1, "sim_irq_first", 32'h1);
    drain();
    step();
    address    = 2'd3;
    writedata  = 32'h04;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    ex(1, "sim_irq_kept", 32'h1);
    drain();
    step();
    ex(0, "sim_ecap_kept", 32'h04);
    drain();
    wr_reg(2'd3, 32'h04);
    ex(1, "sim_irq_clr", 32'h0);
    drain();
    in8 = 8'h00;
    steps(3);

    // level irq mode
    wr_reg(2'd2, 32'h80);
    in_lvl = 8'h80;
    step();
    ex(3, "lvl_irq_early", 32'h0);
    drain();
    step();
    ex(3, "lvl_irq_on", 32'h1);
    ex(1, "lvl_edge_quiet", 32'h0);
    drain();
    in_lvl = 8'h00;
    step();
    ex(3, "lvl_irq_hold", 32'h1);
    drain();
    step();
    ex(3, "lvl_irq_off", 32'h0);
    drain();

    // 32-bit any-edge on bit 31, zero extension of narrow instance
    wr_reg(2'd2, 32'hFFFF_FFFF);
    step();
    ex(0, "mask_zext8", 32'h0000_00FF);
    ex(4, "mask_rd32", 32'hFFFF_FFFF);
    drain();
    in32 = 32'h8000_0000;
    steps(2);
    ex(5, "w32_rise_early", 32'h0);
    drain();
    step();
    ex(5, "w32_rise_irq", 32'h1);
    drain();
    address = 2'd3;
    step();
    ex(4, "w32_rise_ecap", 32'h8000_0000);
    drain();
    wr_reg(2'd3, 32'h8000_0000);
    ex(5, "w32_clr_irq", 32'h0);
    drain();
    in32 = 32'h0;
    steps(2);
    ex(5, "w32_fall_early", 32'h0);
    drain();
    step();
    ex(5, "w32_fall_irq", 32'h1);
    drain();
    step();
    ex(4, "w32_fall_ecap", 32'h8000_0000);
    drain();

    // asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    ex(5, "arst_irq32", 32'h0);
    ex(4, "arst_rd32", 32'h0);
    drain();
    steps(2);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      step();
      all_zero($sformatf("post_a%0d", a));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_input_irq.md
# pio_input_irq

Parametrised Avalon-MM input PIO slave, the next generation of the 8-bit read-only input port in the atividade5 system. Samples an external input bus of configurable width through a configurable synchroniser, exposes level data, a per-bit interrupt mask and a write-1-to-clear edge-capture register, and drives one interrupt line. It is instantiated under the system interconnect as an `s1` Avalon slave, with 2-bit word addressing and 32-bit readdata.

## Interface
- DATA_WIDTH, 8: input bus width, legal range 1..32.
- SYNC_STAGES, 2: synchroniser flops on `in_port`, legal range 0..3. 0 means `in_port` is used directly and must already be synchronous to `clk`.
- EDGE_TYPE, 0: edge type captured. 0 = rising, 1 = falling, 2 = any.
- IRQ_MODE, 1: 0 = level (irq from masked data), 1 = edge (irq from masked edge-capture).

Ports:
- clk  in  1  system clock; all flops rise on this edge.
- reset_n  in  1  reset, asynchronous and active-low; clears every flop.
- address  in  2  word address.
- chipselect  in  1  slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  DATA_WIDTH  external inputs.
- readdata  out  32  registered read data, zero-extended above DATA_WIDTH.
- irq  out  1  interrupt request, active-high.

## Operation
- Register map:
  - 0 = data (RO, synchronised input).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = irqmask (RW, DATA_WIDTH bits).
  - 3 = edgecapture (read; write-1-to-clear).
- Write strobe: `wr = chipselect & ~write_n`.
  - A write to 0 or 1 has no effect.
  - A write to 2 loads `writedata[DATA_WIDTH-1:0]`; upper bits are ignored.
- Synchroniser: chain of SYNC_STAGES flops, each reset to 0. Its output is `data_in`.
- Edge detect:
  - `data_d` is a one-cycle delayed copy of `data_in`, reset to 0.
  - `rise = data_in & ~data_d`; `fall = ~data_in & data_d`; `any = rise | fall`. The event vector is selected by EDGE_TYPE.
- edgecapture bit i:
  - Set on event i.
  - Cleared by `wr` to address 3 with `writedata[i] = 1`.
  - If set and clear occur in the same cycle, set wins (no event lost).
  - Writing 0 to a bit leaves it unchanged.
- irq is a combinational OR-reduce of registered values, with no added latency:
  - IRQ_MODE 0: `|(data_in & irqmask)`.
  - IRQ_MODE 1: `|(edgecapture & irqmask)`.
- readdata:
  - Updated on every clk edge, independent of chipselect, from the mux on `address`.
  - Bits 31..DATA_WIDTH are always 0.
  - Reads have no side effects; reading edgecapture does not clear it.
- Reset values:
  - readdata = 0, irq = 0.
  - irqmask, edgecapture, data_d and synchroniser flops all = 0.
- Reset asserted mid-operation clears pending captures and the mask immediately; irq drops asynchronously.
- Reset release with `in_port` bits high: because `data_d` resets to 0, those bits register a rising edge (EDGE_TYPE 0 or 2) once they emerge from the synchroniser. Software clears edgecapture after enabling. This is intended behaviour.

## Timing
- Let N = SYNC_STAGES. `in_port` is stable before clk edge 1.
  - `data_in` changes after edge N. For N = 0 it changes combinationally.
  - The edgecapture bit sets at edge N+1.
  - Level irq (mode 0) asserts after edge N.
  - Edge irq (mode 1) asserts after edge N+1.
  - A read of address 0 shows the new value in readdata after edge N+1.
- Read latency: readdata reflects `address` as sampled at edge k, valid after edge k (1 cycle, fixed).
- irqmask write at edge k:
  - Takes effect on irq after edge k.
  - Visible in readdata after edge k+1 when address = 2 is held.
- edgecapture clear at edge k: the bit is 0 after edge k and irq deasserts after edge k, unless a new event arrives in the same cycle.
- A pulse on `in_port` shorter than one clk period may be missed. A pulse of at least 1 cycle produces both a rising and a falling event N cycles later.

## Test plan
- Reset then idle, DATA_WIDTH=8, `in_port`=0x00 → readdata=0 at all addresses, irq=0.
- DATA_WIDTH=8, N=2: `in_port`=0xA5 → address 0 reads 0x000000A5 exactly 3 cycles after the change; address 1 reads 0.
- EDGE_TYPE=0, IRQ_MODE=1: irqmask=0x01, pulse `in_port[0]` high for 1 cycle → edgecapture=0x01 at edge N+1 and irq=1; write 0x01 to address 3 → edgecapture=0, irq=0.
- Simultaneous event: a rising edge on bit 2 lands in the same cycle as a write of 0x04 to address 3 → bit 2 stays set, irq stays 1 with irqmask=0x04.
- IRQ_MODE=0, irqmask=0x80: `in_port`=0x80 → irq=1 after edge N; `in_port`=0x00 → irq=0 after edge N.
- DATA_WIDTH=32, EDGE_TYPE=2: toggle `in_port[31]` 0→1→0 → edgecapture=0x80000000 after each edge. Assert reset_n low mid-test → irq=0 and all registers read 0 after reset release.
